// File: rtl/view_pose_scheduler_if.sv
// Pose handshake bundle between the kart engines (master) and the view pose scheduler (slave).
// The engines hold valid and data until the scheduler raises ready.
interface view_pose_scheduler_if;
  logic        p_valid_in;
  logic [10:0] p_x_in;
  logic [10:0] p_y_in;
  logic [8:0]  p_dir_in;
  logic        p_ready_out;
  logic        o_valid_in;
  logic [10:0] o_x_in;
  logic [10:0] o_y_in;
  logic        o_ready_out;

  modport master (
    output p_valid_in, p_x_in, p_y_in, p_dir_in,
    output o_valid_in, o_x_in, o_y_in,
    input  p_ready_out, o_ready_out
  );

  modport slave (
    input  p_valid_in, p_x_in, p_y_in, p_dir_in,
    input  o_valid_in, o_x_in, o_y_in,
    output p_ready_out, o_ready_out
  );
endinterface

// File: rtl/view_pose_scheduler.sv
// Once-per-frame pose collector: requests poses at the start of vertical blanking,
// gathers them with a timeout and commits them to the renderer in a single cycle.
module view_pose_scheduler #(
  parameter int V_ACTIVE  = 720,
  parameter int TIMEOUT   = 16384,
  parameter int P_START_X = 128,
  parameter int P_START_Y = 128,
  parameter int O_START_X = 192,
  parameter int O_START_Y = 128
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  view_pose_scheduler_if.slave   pose,
  output logic                   frame_req_out,
  output logic [10:0]            player_x_out,
  output logic [10:0]            player_y_out,
  output logic [10:0]            opponent_x_out,
  output logic [10:0]            opponent_y_out,
  output logic [8:0]             direction_out,
  output logic                   update_out,
  output logic [7:0]             miss_count_out
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {WAIT_BLANK, COLLECT, COMMIT} state_t;

  state_t        state;
  logic [CW-1:0] timeout_count;
  logic          got_p;
  logic          got_o;
  logic [10:0]   shadow_p_x;
  logic [10:0]   shadow_p_y;
  logic [8:0]    shadow_p_dir;
  logic [10:0]   shadow_o_x;
  logic [10:0]   shadow_o_y;

  logic          frame_start;
  logic          p_take;
  logic          o_take;
  logic          got_p_next;
  logic          got_o_next;
  logic [8:0]    dir_norm;

  assign frame_start = (vcount_in == 10'(V_ACTIVE)) && (hcount_in == 11'd0);
  assign p_take      = (state == COLLECT) && pose.p_valid_in && pose.p_ready_out;
  assign o_take      = (state == COLLECT) && pose.o_valid_in && pose.o_ready_out;
  assign got_p_next  = got_p | p_take;
  assign got_o_next  = got_o | o_take;
  // 9-bit heading tops out at 511, so a single subtraction lands in 0..359
  assign dir_norm    = (pose.p_dir_in >= 9'd360) ? (pose.p_dir_in - 9'd360) : pose.p_dir_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= WAIT_BLANK;
      timeout_count    <= '0;
      got_p            <= 1'b0;
      got_o            <= 1'b0;
      pose.p_ready_out <= 1'b0;
      pose.o_ready_out <= 1'b0;
      frame_req_out    <= 1'b0;
      update_out       <= 1'b0;
      miss_count_out   <= 8'd0;
      player_x_out     <= 11'(P_START_X);
      player_y_out     <= 11'(P_START_Y);
      opponent_x_out   <= 11'(O_START_X);
      opponent_y_out   <= 11'(O_START_Y);
      direction_out    <= 9'd0;
      shadow_p_x       <= 11'(P_START_X);
      shadow_p_y       <= 11'(P_START_Y);
      shadow_p_dir     <= 9'd0;
      shadow_o_x       <= 11'(O_START_X);
      shadow_o_y       <= 11'(O_START_Y);
    end else begin
      frame_req_out <= 1'b0;
      update_out    <= 1'b0;
      case (state)
        WAIT_BLANK: begin
          pose.p_ready_out <= 1'b0;
          pose.o_ready_out <= 1'b0;
          if (frame_start) begin
            state            <= COLLECT;
            got_p            <= 1'b0;
            got_o            <= 1'b0;
            timeout_count    <= '0;
            frame_req_out    <= 1'b1;
            pose.p_ready_out <= 1'b1;
            pose.o_ready_out <= 1'b1;
          end
        end
        COLLECT: begin
          if (p_take) begin
            shadow_p_x   <= pose.p_x_in;
            shadow_p_y   <= pose.p_y_in;
            shadow_p_dir <= dir_norm;
            got_p        <= 1'b1;
          end
          if (o_take) begin
            shadow_o_x <= pose.o_x_in;
            shadow_o_y <= pose.o_y_in;
            got_o      <= 1'b1;
          end
          timeout_count <= timeout_count + 1'b1;
          // Readys drop on the same edge that closes collection
          if ((got_p_next && got_o_next) || (timeout_count == LAST_COUNT)) begin
            state            <= COMMIT;
            pose.p_ready_out <= 1'b0;
            pose.o_ready_out <= 1'b0;
          end else begin
            pose.p_ready_out <= !got_p_next;
            pose.o_ready_out <= !got_o_next;
          end
        end
        COMMIT: begin
          if (got_p) begin
            player_x_out  <= shadow_p_x;
            player_y_out  <= shadow_p_y;
            direction_out <= shadow_p_dir;
          end
          if (got_o) begin
            opponent_x_out <= shadow_o_x;
            opponent_y_out <= shadow_o_y;
          end
          update_out <= 1'b1;
          if (!(got_p && got_o) && (miss_count_out != 8'hFF)) begin
            miss_count_out <= miss_count_out + 8'd1;
          end
          state <= WAIT_BLANK;
        end
        default: begin
          state <= WAIT_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_view_pose_scheduler.sv
// Directed self-checking bench for view_pose_scheduler with a shortened timeout.
module tb_view_pose_scheduler;

  localparam int TIMEOUT = 16;

  logic        clk_in;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        frame_req_out;
  logic [10:0] player_x_out;
  logic [10:0] player_y_out;
  logic [10:0] opponent_x_out;
  logic [10:0] opponent_y_out;
  logic [8:0]  direction_out;
  logic        update_out;
  logic [7:0]  miss_count_out;

  int checks;
  int errors;

  view_pose_scheduler_if pose_if ();

  view_pose_scheduler #(
    .V_ACTIVE (720),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .pose           (pose_if),
    .frame_req_out  (frame_req_out),
    .player_x_out   (player_x_out),
    .player_y_out   (player_y_out),
    .opponent_x_out (opponent_x_out),
    .opponent_y_out (opponent_y_out),
    .direction_out  (direction_out),
    .update_out     (update_out),
    .miss_count_out (miss_count_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic pv, input int px, input int py, input int pd,
                               input logic ov, input int ox, input int oy);
    pose_if.p_valid_in = pv;
    pose_if.p_x_in     = 11'(px);
    pose_if.p_y_in     = 11'(py);
    pose_if.p_dir_in   = 9'(pd);
    pose_if.o_valid_in = ov;
    pose_if.o_x_in     = 11'(ox);
    pose_if.o_y_in     = 11'(oy);
  endtask

  // Leaves the bench just after the edge that samples the frame-start match
  task automatic frameStart();
    vcount_in = 10'd720;
    hcount_in = 11'd0;
    step();
    vcount_in = 10'd721;
    hcount_in = 11'd3;
  endtask

  task automatic waitUpdate(input string tag, output int n);
    n = 0;
    while (update_out !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    checkOutput(tag, update_out, 1);
  endtask

  initial begin
    int n;
    int ones_p;
    int ones_o;
    int ones_u;
    checks    = 0;
    errors    = 0;
    rst_in    = 1'b0;
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    checkOutput("rst_p_ready", pose_if.p_ready_out, 0);
    checkOutput("rst_o_ready", pose_if.o_ready_out, 0);
    checkOutput("rst_player_x", player_x_out, 128);
    checkOutput("rst_player_y", player_y_out, 128);
    checkOutput("rst_opp_x", opponent_x_out, 192);
    checkOutput("rst_opp_y", opponent_y_out, 128);
    checkOutput("rst_dir", direction_out, 0);
    checkOutput("rst_miss", miss_count_out, 0);
    checkOutput("rst_update", update_out, 0);
    checkOutput("rst_frame_req", frame_req_out, 0);
    rst_in = 1'b1;
    step();

    // Two frames with silent engines
    for (int f = 0; f < 2; f++) begin
      frameStart();
      checkOutput("silent_frame_req", frame_req_out, 1);
      checkOutput("silent_p_ready", pose_if.p_ready_out, 1);
      checkOutput("silent_o_ready", pose_if.o_ready_out, 1);
      waitUpdate("silent_update", n);
      checkOutput("silent_len", n, TIMEOUT + 1);
      checkOutput("silent_player_x", player_x_out, 128);
      checkOutput("silent_opp_x", opponent_x_out, 192);
      checkOutput("silent_dir", direction_out, 0);
      checkOutput("silent_miss", miss_count_out, f + 1);
      step();
      checkOutput("silent_update_width", update_out, 0);
    end

    // Both sources on the same edge, three cycles into collection
    frameStart();
    checkOutput("both_frame_req", frame_req_out, 1);
    step();
    checkOutput("both_frame_req_pulse", frame_req_out, 0);
    step();
    applyStimulus(1, 300, 400, 90, 1, 310, 405);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("both_p_ready_after", pose_if.p_ready_out, 0);
    checkOutput("both_o_ready_after", pose_if.o_ready_out, 0);
    checkOutput("both_update_early", update_out, 0);
    checkOutput("both_player_x_hold", player_x_out, 128);
    step();
    checkOutput("both_update", update_out, 1);
    checkOutput("both_player_x", player_x_out, 300);
    checkOutput("both_player_y", player_y_out, 400);
    checkOutput("both_dir", direction_out, 90);
    checkOutput("both_opp_x", opponent_x_out, 310);
    checkOutput("both_opp_y", opponent_y_out, 405);
    checkOutput("both_miss", miss_count_out, 2);
    step();
    checkOutput("both_update_width", update_out, 0);

    // Heading 400 wraps to 40; opponent arrives ten cycles later
    frameStart();
    applyStimulus(1, 500, 600, 400, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    ones_p = 0;
    ones_o = 0;
    for (int i = 0; i < 10; i++) begin
      ones_p += int'(pose_if.p_ready_out);
      ones_o += int'(pose_if.o_ready_out);
      step();
    end
    checkOutput("gap_p_ready_low", ones_p, 0);
    checkOutput("gap_o_ready_high", ones_o, 10);
    applyStimulus(0, 0, 0, 0, 1, 700, 710);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("gap_update", update_out, 1);
    checkOutput("gap_dir", direction_out, 40);
    checkOutput("gap_player_x", player_x_out, 500);
    checkOutput("gap_opp_x", opponent_x_out, 700);
    checkOutput("gap_opp_y", opponent_y_out, 710);
    checkOutput("gap_miss", miss_count_out, 2);

    // Opponent silent: timeout commit keeps its previous pose
    frameStart();
    applyStimulus(1, 1000, 50, 359, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    n = 0;
    waitUpdate("to_update", n);
    checkOutput("to_len", n + 1, TIMEOUT + 1);
    checkOutput("to_player_x", player_x_out, 1000);
    checkOutput("to_player_y", player_y_out, 50);
    checkOutput("to_dir", direction_out, 359);
    checkOutput("to_opp_x", opponent_x_out, 700);
    checkOutput("to_opp_y", opponent_y_out, 710);
    checkOutput("to_miss", miss_count_out, 3);

    for (int f = 0; f < 300; f++) begin
      frameStart();
      waitUpdate("sat_update", n);
    end
    checkOutput("sat_miss", miss_count_out, 255);

    // Heading boundaries 360 -> 0 and 511 -> 151
    frameStart();
    applyStimulus(1, 222, 333, 360, 1, 444, 555);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("d360_update", update_out, 1);
    checkOutput("d360_dir", direction_out, 0);
    checkOutput("d360_player_x", player_x_out, 222);
    checkOutput("d360_miss", miss_count_out, 255);
    frameStart();
    applyStimulus(1, 222, 333, 511, 1, 444, 555);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("d511_dir", direction_out, 151);

    // Valid during active video is never accepted
    vcount_in = 10'd100;
    applyStimulus(1, 7, 8, 9, 1, 10, 11);
    ones_p = 0;
    ones_u = 0;
    for (int i = 0; i < 20; i++) begin
      hcount_in = 11'(i);
      step();
      ones_p += int'(pose_if.p_ready_out);
      ones_u += int'(update_out);
    end
    checkOutput("active_p_ready", ones_p, 0);
    checkOutput("active_update", ones_u, 0);
    checkOutput("active_player_x", player_x_out, 222);
    checkOutput("active_dir", direction_out, 151);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset between player and opponent capture
    frameStart();
    applyStimulus(1, 11, 22, 33, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_in = 1'b0;
    #2;
    checkOutput("mid_rst_p_ready", pose_if.p_ready_out, 0);
    checkOutput("mid_rst_o_ready", pose_if.o_ready_out, 0);
    checkOutput("mid_rst_player_x", player_x_out, 128);
    checkOutput("mid_rst_opp_x", opponent_x_out, 192);
    checkOutput("mid_rst_dir", direction_out, 0);
    checkOutput("mid_rst_miss", miss_count_out, 0);
    step();
    rst_in = 1'b1;
    ones_u = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      ones_u += int'(update_out);
    end
    checkOutput("mid_rst_no_update", ones_u, 0);
    checkOutput("mid_rst_player_x_hold", player_x_out, 128);
    frameStart();
    applyStimulus(1, 50, 60, 70, 1, 80, 90);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("resume_update", update_out, 1);
    checkOutput("resume_player_x", player_x_out, 50);
    checkOutput("resume_player_y", player_y_out, 60);
    checkOutput("resume_dir", direction_out, 70);
    checkOutput("resume_opp_x", opponent_x_out, 80);
    checkOutput("resume_opp_y", opponent_y_out, 90);
    checkOutput("resume_miss", miss_count_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/view_pose_scheduler.md
# view_pose_scheduler

Per-frame scheduler that supplies the forward-view renderer's pose inputs: the player's position and heading and the opponent's position. At the start of vertical blanking it requests a fresh pose from the player and opponent kart engines over valid/ready handshakes. It collects the poses with a timeout and commits them to its outputs in a single cycle. The renderer therefore never sees a pose change mid-frame. It sits between the kart physics blocks and the forward view, in the pixel clock domain.

## Interface
- V_ACTIVE, 720: first blanking line; frame start is vcount_in==V_ACTIVE && hcount_in==0
- TIMEOUT, 16384: maximum COLLECT cycles; must be less than blanking length in cycles
- P_START_X, 128: player_x_out reset value
- P_START_Y, 128: player_y_out reset value
- O_START_X, 192: opponent_x_out reset value
- O_START_Y, 128: opponent_y_out reset value
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous, active-low reset
- hcount_in  in  11  raster horizontal count
- vcount_in  in  10  raster vertical count
- p_valid_in  in  1  player pose valid
- p_x_in, p_y_in  in  11 each  player position
- p_dir_in  in  9  player heading, degrees
- p_ready_out  out  1  player pose accepted when valid && ready
- o_valid_in  in  1  opponent pose valid
- o_x_in, o_y_in  in  11 each  opponent position
- o_ready_out  out  1  opponent pose ready
- frame_req_out  out  1  one-cycle pulse asking engines for a new pose
- player_x_out, player_y_out, opponent_x_out, opponent_y_out  out  11 each  committed poses
- direction_out  out  9  committed heading, range 0..359
- update_out  out  1  one-cycle pulse on commit
- miss_count_out  out  8  saturating count of frames with at least one missed source

## Operation
- States: WAIT_BLANK, COLLECT, COMMIT.
- Reset values: state WAIT_BLANK; all readys 0; frame_req_out 0; update_out 0; direction_out 0; miss_count_out 0; positions take their START parameters; shadow registers take the same values; got_p and got_o are 0.
- WAIT_BLANK: readys are low. On a frame-start match, go to COLLECT and clear got_p, got_o and the timeout counter. frame_req_out is high for the first COLLECT cycle.
- COLLECT:
  - p_ready_out = !got_p and o_ready_out = !got_o.
  - A handshake (valid && ready at a clock edge) loads that source's shadow registers and sets its got flag. Both sources may handshake in the same cycle.
  - The counter increments every cycle.
  - Go to COMMIT when got_p && got_o, or when the counter reaches TIMEOUT-1.
- COMMIT, one cycle:
  - Copy only the sources whose got flag is set from shadow to outputs. A missed source keeps its previous outputs.
  - Pulse update_out.
  - If either got flag is clear, increment miss_count_out, saturating at 255.
  - Return to WAIT_BLANK.
- Heading normalisation at capture: if p_dir_in >= 360, store p_dir_in - 360; otherwise store p_dir_in. A 9-bit input gives at most 511, which maps to 151, so one subtraction is sufficient.
- A frame-start match outside WAIT_BLANK is ignored.
- Valid outside COLLECT is not accepted. The source must hold valid and its data until ready.
- Raster inputs are not checked for range. Only the exact frame-start match matters.

## Timing
- Edge E0 samples the frame-start match. After E0 the state is COLLECT, frame_req_out = 1, and readys are high unless the source was already captured.
- An accepting edge Ek sets the got flag, and that source's ready is low after Ek.
- When the final capture is at Ek, the state is COMMIT after Ek. At Ek+1 the outputs load; update_out is high for exactly the cycle after Ek+1.
- Timeout: a COLLECT with no captures lasts exactly TIMEOUT cycles, followed by the commit edge.
- Because TIMEOUT is less than the blanking length, outputs only ever change during vertical blanking.
- Reset mid-operation: asynchronous return to all reset values. Any partial capture is discarded and no commit occurs.

## Test plan
- Reset with rst_in=0: check readys=0, player_x_out=128, opponent_x_out=192, direction_out=0, miss_count_out=0. Check the outputs hold through two frames when neither engine responds, with miss_count_out reaching 2.
- Frame start; player valid 3 cycles later with (300, 400, 90); opponent valid on the same edge with (310, 405) -> one cycle of frame_req_out. Expect one capture edge, update_out exactly 2 cycles after the capture, outputs 300/400/90/310/405, and miss_count_out unchanged.
- Player responds with p_dir_in=400; opponent responds 10 cycles later -> direction_out=40, and p_ready_out is low during the 10-cycle gap.
- Opponent never responds, TIMEOUT=16 -> commit occurs 16 cycles after COLLECT entry. Player outputs update, opponent outputs are unchanged, and miss_count_out increments by 1. After 300 such frames miss_count_out holds at 255.
- p_valid_in held high during active video -> p_ready_out stays 0 and no output changes until the next frame start.
- Assert rst_in low for one cycle after the player capture but before the opponent capture -> all reset values return, no update_out pulse, and normal collection resumes at the next frame start.
